// File: rtl/music_seq_ctrl.sv
// music_seq_ctrl: steps a note-period ROM once per beat and drives a square-wave buzzer
module music_seq_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int NOTE_W      = 20,
  parameter int SONG_LEN    = 144,
  parameter int BEAT_CYCLES = 6250000,
  parameter int REST_PERIOD = 2500,
  parameter int LOOP        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  output logic              buzzer,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);
  localparam int BW = BEAT_CYCLES > 1 ? $clog2(BEAT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt, idx_nxt;
  logic [NOTE_W-1:0] period_reg, period_nxt, tone_cnt, tone_nxt;
  logic [BW-1:0]     beat_cnt, beat_nxt;
  logic              buzzer_nxt, done_nxt, run, last, rest;
  assign busy = state != IDLE;
  assign run  = state == PLAY && !pause;
  assign last = run && beat_cnt == BW'(BEAT_CYCLES - 1);
  // a zero period is what an out-of-range ROM read returns, so it is silent too
  assign rest = period_reg == '0 || period_reg == NOTE_W'(REST_PERIOD);
  always_comb begin
    state_nxt  = state;
    addr_nxt   = rom_addr;
    idx_nxt    = note_idx;
    period_nxt = period_reg;
    tone_nxt   = tone_cnt;
    beat_nxt   = beat_cnt;
    buzzer_nxt = 1'b0;
    done_nxt   = 1'b0;
    if (state == FETCH) state_nxt = LOAD;
    if (state == LOAD) begin
      state_nxt  = PLAY;
      period_nxt = rom_note;
      idx_nxt    = rom_addr;
      tone_nxt   = '0;
      beat_nxt   = '0;
    end
    if (run) begin
      beat_nxt   = beat_cnt + BW'(1);
      tone_nxt   = (rest || tone_cnt == period_reg - NOTE_W'(1)) ? '0 : tone_cnt + NOTE_W'(1);
      buzzer_nxt = !rest && tone_cnt < (period_reg >> 1);
    end
    if (last) begin
      state_nxt = (rom_addr < ADDR_W'(SONG_LEN - 1) || LOOP != 0) ? FETCH : IDLE;
      addr_nxt  = rom_addr < ADDR_W'(SONG_LEN - 1) ? rom_addr + ADDR_W'(1) :
                  LOOP != 0 ? '0 : rom_addr;
      done_nxt  = !(rom_addr < ADDR_W'(SONG_LEN - 1)) && LOOP == 0;
    end
    // start restarts from any state; stop overrides it
    if (start) begin
      state_nxt  = FETCH;
      addr_nxt   = '0;
      buzzer_nxt = 1'b0;
    end
    if (stop) begin
      state_nxt  = IDLE;
      addr_nxt   = '0;
      buzzer_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      note_idx   <= '0;
      period_reg <= '0;
      tone_cnt   <= '0;
      beat_cnt   <= '0;
      buzzer     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rom_addr   <= addr_nxt;
      note_idx   <= idx_nxt;
      period_reg <= period_nxt;
      tone_cnt   <= tone_nxt;
      beat_cnt   <= beat_nxt;
      buzzer     <= buzzer_nxt;
      done       <= done_nxt;
    end
  end
endmodule

// File: tb/tb_music_seq_ctrl.sv
// tb_music_seq_ctrl: directed checks of play, loop, pause, stop/start, restart and reset
module tb_music_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic        start_l = 1'b0, stop_l = 1'b0, pause_l = 1'b0;
  logic [7:0]  rom_addr, note_idx, rom_addr_l, note_idx_l;
  logic [19:0] rom_note, rom_note_l;
  logic        buzzer, busy, done, buzzer_l, busy_l, done_l;
  logic [19:0] rom_tbl [0:3];
  logic [7:0]  addr_log [0:119];
  logic [7:0]  laddr_log [0:119];
  logic        buz_log [0:119];
  logic        done_log [0:119];
  logic        busy_log [0:119];
  logic        ldone_log [0:119];
  logic        lbusy_log [0:119];
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  music_seq_ctrl #(.ADDR_W(8), .NOTE_W(20), .SONG_LEN(4), .BEAT_CYCLES(20), .REST_PERIOD(2500), .LOOP(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .rom_addr(rom_addr), .rom_note(rom_note), .buzzer(buzzer), .busy(busy),
    .done(done), .note_idx(note_idx));
  music_seq_ctrl #(.ADDR_W(8), .NOTE_W(20), .SONG_LEN(4), .BEAT_CYCLES(20), .REST_PERIOD(2500), .LOOP(1)) dut_loop (
    .clk(clk), .rst_n(rst_n), .start(start_l), .stop(stop_l), .pause(pause_l),
    .rom_addr(rom_addr_l), .rom_note(rom_note_l), .buzzer(buzzer_l), .busy(busy_l),
    .done(done_l), .note_idx(note_idx_l));
  initial begin
    rom_tbl[0] = 20'd8;
    rom_tbl[1] = 20'd2500;
    rom_tbl[2] = 20'd7;
    rom_tbl[3] = 20'd0;
  end
  always_ff @(posedge clk) begin
    rom_note   <= rom_addr < 8'd4 ? rom_tbl[rom_addr[1:0]] : 20'd0;
    rom_note_l <= rom_addr_l < 8'd4 ? rom_tbl[rom_addr_l[1:0]] : 20'd0;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int count_buz(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(buz_log[i]);
    return n;
  endfunction
  task automatic capture(input int n, input int p_lo, input int p_hi);
    for (int c = 0; c < n; c++) begin
      addr_log[c]  = rom_addr;
      buz_log[c]   = buzzer;
      done_log[c]  = done;
      busy_log[c]  = busy;
      laddr_log[c] = rom_addr_l;
      ldone_log[c] = done_l;
      lbusy_log[c] = busy_l;
      pause = c >= p_lo && c < p_hi;
      @(negedge clk);
    end
    pause = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic go_idle();
    stop = 1'b1;
    stop_l = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    stop_l = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int dn;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_done", done, 0);
    check("rst_note_idx", note_idx, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // basic play plus the looping instance started on the same cycle
    start = 1'b1;
    start_l = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_l = 1'b0;
    capture(120, -1, -1);
    check("play_busy0", busy_log[0], 1);
    check("play_addr0", addr_log[0], 0);
    check("play_addr21", addr_log[21], 0);
    check("play_addr22", addr_log[22], 1);
    check("play_addr43", addr_log[43], 1);
    check("play_addr44", addr_log[44], 2);
    check("play_addr66", addr_log[66], 3);
    check("play_addr_hold", addr_log[95], 3);
    check("e0_buz2", buz_log[2], 0);
    check("e0_buz3", buz_log[3], 1);
    check("e0_buz6", buz_log[6], 1);
    check("e0_buz7", buz_log[7], 0);
    check("e0_buz11", buz_log[11], 1);
    check("e0_highs", count_buz(0, 22), 12);
    check("e1_rest", count_buz(23, 46), 0);
    check("e2_buz49", buz_log[49], 1);
    check("e2_buz50", buz_log[50], 0);
    check("e2_buz54", buz_log[54], 1);
    check("e2_highs", count_buz(47, 66), 9);
    check("e3_zero", count_buz(67, 119), 0);
    check("done87", done_log[87], 0);
    check("done88", done_log[88], 1);
    check("busy87", busy_log[87], 1);
    check("busy88", busy_log[88], 0);
    dn = 0;
    for (int i = 0; i < 120; i++) dn += int'(done_log[i]);
    check("done_once", dn, 1);
    dn = 0;
    for (int i = 0; i < 120; i++) dn += int'(ldone_log[i]);
    check("loop_no_done", dn, 0);
    check("loop_addr87", laddr_log[87], 3);
    check("loop_addr88", laddr_log[88], 0);
    check("loop_addr110", laddr_log[110], 1);
    check("loop_busy", lbusy_log[100], 1);
    go_idle();
    // pause for 10 cycles at beat 5 of entry 0
    pulse_start();
    capture(40, 7, 17);
    check("pz_buz6", buz_log[6], 1);
    check("pz_quiet", count_buz(8, 17), 0);
    check("pz_buz20", buz_log[20], 0);
    check("pz_buz21", buz_log[21], 1);
    check("pz_highs", count_buz(0, 32), 12);
    check("pz_addr31", addr_log[31], 0);
    check("pz_addr32", addr_log[32], 1);
    go_idle();
    // stop and start together mid entry 2
    pulse_start();
    repeat (50) @(negedge clk);
    check("ss_pre_addr", rom_addr, 2);
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_addr", rom_addr, 0);
    check("ss_buzzer", buzzer, 0);
    repeat (4) @(negedge clk);
    check("ss_stay_idle", busy, 0);
    pulse_start();
    check("ss_restart_busy", busy, 1);
    repeat (2) @(negedge clk);
    check("ss_restart_idx", note_idx, 0);
    // restart during entry 1, then async reset while the buzzer is high
    repeat (28) @(negedge clk);
    check("rs_pre_addr", rom_addr, 1);
    pulse_start();
    check("rs_addr", rom_addr, 0);
    check("rs_busy", busy, 1);
    repeat (2) @(negedge clk);
    check("rs_idx", note_idx, 0);
    @(negedge clk);
    check("rs_buz_high", buzzer, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_addr", rom_addr, 0);
    check("ar_buzzer", buzzer, 0);
    check("ar_idx", note_idx, 0);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      dn += int'(done);
    end
    check("ar_no_done", dn, 0);
    check("ar_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
